// File: rtl/rn_sample_tx.sv
// rn_sample_tx: buffers clocked real samples and emits them one per slot as a change-carrying real output
module rn_sample_tx #(
    parameter int  DEPTH    = 16,
    parameter int  PREFILL  = 8,
    parameter int  RATE_DIV = 4,
    parameter real NUDGE    = 1e-12,
    parameter int  CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_valid,
    input  real                    in_data,
    output logic                   in_ready,
    output real                    vout,
    output logic                   vout_strobe,
    output logic [$clog2(DEPTH):0] fill,
    output logic [1:0]             state,
    output logic [CNT_W-1:0]       underflow_cnt,
    output logic [CNT_W-1:0]       sample_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int DW = RATE_DIV > 1 ? $clog2(RATE_DIV) : 1;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PREFILL = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] div_cnt;
    logic [63:0]   vout_bits;
    logic [1:0]    state_d;
    logic          push;
    logic          pop;
    logic          underflow;
    logic          slot;
    logic          go_run;
    real           head;
    real           next_v;

    assign in_ready = fill < FW'(DEPTH);
    assign vout     = $bitstoreal(vout_bits);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next state: pause wins, prefill gates the run, an empty slot falls back to prefill
    always_comb begin
        go_run  = en && state == S_PREFILL && fill >= FW'(PREFILL);
        state_d = !en              ? S_IDLE    :
                  state == S_IDLE  ? S_PREFILL :
                  go_run           ? S_RUN     :
                  underflow        ? S_PREFILL : state;
    end

    // Slot decisions use the registered fill, so a same-cycle push is never popped
    always_comb begin
        slot      = en && state == S_RUN && div_cnt == '0;
        pop       = slot && fill != '0;
        underflow = slot && fill == '0;
        push      = in_valid && in_ready;
        head      = $bitstoreal(mem[rd_ptr]);
        next_v    = head == vout ? head + NUDGE : head;
    end

    // Sample storage, written on accepted pushes
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= $realtobits(in_data);
    end

    // Pointers, occupancy, slot divider, output value and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill          <= '0;
            div_cnt       <= '0;
            vout_bits     <= '0;
            vout_strobe   <= 1'b0;
            underflow_cnt <= '0;
            sample_cnt    <= '0;
        end else begin
            vout_strobe <= pop;
            fill        <= fill + FW'(push) - FW'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                vout_bits  <= $realtobits(next_v);
                sample_cnt <= sample_cnt + 1'b1;
            end
            if (underflow && underflow_cnt != '1) underflow_cnt <= underflow_cnt + 1'b1;
            if (go_run)
                div_cnt <= '0;
            else if (pop)
                div_cnt <= DW'(1 % RATE_DIV);
            else if (en && state == S_RUN && div_cnt != '0)
                div_cnt <= div_cnt == DW'(RATE_DIV - 1) ? '0 : div_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rn_sample_tx.sv
// tb_rn_sample_tx: directed and randomized checks of rn_sample_tx against a queue-based reference model
module tb_rn_sample_tx;
    localparam int  DEPTH    = 16;
    localparam int  PREFILL  = 8;
    localparam int  RATE_DIV = 4;
    localparam real NUDGE    = 1e-12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    real         in_data = 0.0;
    logic        in_ready;
    real         vout;
    logic        vout_strobe;
    logic [4:0]  fill;
    logic [1:0]  state;
    logic [15:0] underflow_cnt;
    logic [15:0] sample_cnt;

    int  checks = 0;
    int  failures = 0;
    real q[$];
    real emitted[$];
    int  m_state = 0;
    int  m_div = 0;
    int  m_uf = 0;
    int  m_sc = 0;
    real m_vout = 0.0;
    int  m_strobe = 0;
    int  strobes = 0;

    rn_sample_tx #(.DEPTH(DEPTH), .PREFILL(PREFILL), .RATE_DIV(RATE_DIV), .NUDGE(NUDGE), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .vout(vout), .vout_strobe(vout_strobe), .fill(fill),
        .state(state), .underflow_cnt(underflow_cnt), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_r(input string tag, input real got, input real exp);
        checks++;
        assert (got == exp) else begin
            failures++;
            $error("FAIL %s observed=%.15g expected=%.15g", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model by the spec rules, compare every output after the edge
    task automatic step(input bit r, input bit e, input bit v, input real d);
        bit  push;
        bit  emit;
        bit  uf;
        real s;
        rst = r; en = e; in_valid = v; in_data = d;
        #1;
        chk("in_ready", int'(in_ready), int'(q.size() < DEPTH));
        if (r) begin
            q.delete(); m_vout = 0.0; m_strobe = 0; m_state = 0; m_div = 0; m_uf = 0; m_sc = 0;
        end else begin
            push = v && q.size() < DEPTH; emit = 0; uf = 0;
            if (!e) m_state = 0;
            else if (m_state == 0) m_state = 1;
            else if (m_state == 1) begin
                if (q.size() >= PREFILL) begin m_state = 2; m_div = 0; end
            end else if (m_div == 0) begin
                if (q.size() > 0) emit = 1;
                else begin uf = 1; m_state = 1; end
            end else m_div = (m_div + 1) % RATE_DIV;
            if (emit) begin
                s = q.pop_front();
                m_vout = (s == m_vout) ? s + NUDGE : s;
                m_sc = (m_sc + 1) % 65536;
                m_div = 1 % RATE_DIV;
            end
            if (uf && m_uf < 65535) m_uf++;
            if (push) q.push_back(d);
            m_strobe = emit;
        end
        @(posedge clk);
        #1;
        chk_r("vout", vout, m_vout);
        chk("vout_strobe", int'(vout_strobe), m_strobe);
        chk("fill", int'(fill), q.size());
        chk("state", int'(state), m_state);
        chk("underflow_cnt", int'(underflow_cnt), m_uf);
        chk("sample_cnt", int'(sample_cnt), m_sc);
        if (vout_strobe) begin emitted.push_back(vout); strobes++; end
    endtask

    task automatic run_until(input int n, input int budget);
        for (int i = 0; i < budget && emitted.size() < n; i++) step(0, 1, 0, 0.0);
        chk("emit_budget", emitted.size(), n);
    endtask

    initial begin
        real full_data[17];
        real fresh[8];
        real pool[3];
        int  s0;
        int  f0;
        int  budget;
        pool[0] = 0.25; pool[1] = 0.5; pool[2] = 0.75;

        // Reset
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0.0);
        step(0, 0, 0, 0.0);
        chk("rst_state", int'(state), 0);
        chk("rst_fill", int'(fill), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_uf", int'(underflow_cnt), 0);
        chk("rst_sc", int'(sample_cnt), 0);
        chk_r("rst_vout", vout, 0.0);

        // Prefill and run
        emitted.delete();
        for (int k = 1; k <= 8; k++) step(0, 1, 1, 0.1 * k);
        chk("pre_state", int'(state), 1);
        step(0, 1, 0, 0.0);
        chk("run_entered", int'(state), 2);
        run_until(8, 40);
        for (int i = 0; i < 8 && i < emitted.size(); i++) chk_r("run_val", emitted[i], 0.1 * (i + 1));
        chk("run_sc", int'(sample_cnt), 8);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0.0);
        chk("uf_cnt", int'(underflow_cnt), 1);
        chk("uf_state", int'(state), 1);
        chk("uf_nostrobe", int'(vout_strobe), 0);

        // Nudge
        emitted.delete();
        for (int k = 0; k < 8; k++) step(0, 1, 1, 1.0 + real'($urandom_range(0, 999)) / 1000.0);
        step(0, 1, 1, 0.5);
        step(0, 1, 1, 0.5);
        step(0, 1, 1, 0.5);
        step(0, 1, 1, 0.3);
        run_until(12, 80);
        if (emitted.size() >= 12) begin
            chk_r("nudge0", emitted[8], 0.5);
            chk_r("nudge1", emitted[9], 0.5 + 1e-12);
            chk_r("nudge2", emitted[10], 0.5);
            chk_r("nudge3", emitted[11], 0.3);
        end

        // Full
        for (int i = 0; i < 17; i++) full_data[i] = 2.0 + real'(i) + real'($urandom_range(0, 99)) / 1000.0;
        for (int i = 0; i < 17; i++) step(0, 0, 1, full_data[i]);
        chk("full_fill", int'(fill), 16);
        chk("full_ready", int'(in_ready), 0);
        emitted.delete();
        run_until(16, 120);
        for (int i = 0; i < 16 && i < emitted.size(); i++) chk_r("full_order", emitted[i], full_data[i]);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0.0);
        chk("no_17th", emitted.size(), 16);

        // Pause mid-RUN
        for (int k = 0; k < 10; k++) step(0, 1, 1, real'($urandom_range(0, 999)) / 100.0);
        emitted.delete();
        run_until(2, 40);
        s0 = strobes;
        f0 = q.size();
        for (int i = 0; i < 10; i++) step(0, 0, i < 2, 5.0 + real'(i));
        chk("pause_strobes", strobes - s0, 0);
        chk("pause_fill", int'(fill), f0 + 2);
        step(0, 1, 0, 0.0);
        chk("resume_pre", int'(state), 1);
        step(0, 1, 0, 0.0);
        chk("resume_run", int'(state), 2);

        // Push on an emission edge
        budget = 0;
        while (!(m_state == 2 && m_div == 0 && q.size() > 0) && budget < 20) begin
            step(0, 1, 0, 0.0);
            budget++;
        end
        chk("emit_edge_found", int'(budget < 20), 1);
        f0 = q.size();
        step(0, 1, 1, 7.25);
        chk("pushpop_fill", int'(fill), f0);
        chk("pushpop_strobe", int'(vout_strobe), 1);

        // Reset mid-RUN with fill=5
        for (int k = 0; k < 6; k++) step(0, 1, 1, 8.0 + real'(k));
        budget = 0;
        while (!(m_state == 2 && q.size() == 5) && budget < 100) begin
            step(0, 1, 0, 0.0);
            budget++;
        end
        chk("fill5_found", int'(fill), 5);
        step(1, 1, 0, 0.0);
        chk("mrst_fill", int'(fill), 0);
        chk_r("mrst_vout", vout, 0.0);
        chk("mrst_state", int'(state), 0);
        chk("mrst_strobe", int'(vout_strobe), 0);
        for (int i = 0; i < 8; i++) fresh[i] = 20.0 + real'($urandom_range(0, 999)) / 1000.0;
        emitted.delete();
        for (int i = 0; i < 8; i++) step(0, 1, 1, fresh[i]);
        run_until(1, 20);
        if (emitted.size() > 0) chk_r("mrst_fresh", emitted[0], fresh[0]);

        // Randomized traffic with repeated values to exercise nudging
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                 pool[$urandom_range(0, 2)]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
